bsg_bladerunner_rom_reader: RTL and testbench

Requester stage sitting directly upstream of the bladerunner ROM endpoint: walks the configuration ROM by issuing a sequence of word-load requests toward the ROM tile's endpoint and collects the returned words. Returned data is buffered and streamed to a host-side consumer over valid/ready. Outstanding loads are credit-limited so that every response is guaranteed FIFO space, since the endpoint's returning path cannot be back-pressured.

---
 rtl/bsg_bladerunner_rom_reader.sv | 114 +++++++++++
 tb/tb_bsg_bladerunner_rom_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_bladerunner_rom_reader.sv
// bsg_bladerunner_rom_reader: walks the configuration ROM with credit-limited word loads and streams the returned words
//   clk_i, reset_n_i      : clock, asynchronous active-low reset
//   start_i, num_words_i  : begin a run of num_words_i loads (sampled in IDLE only)
//   busy_o, done_o        : run in progress / one-cycle end-of-run pulse
//   error_o               : sticky, a response arrived with nothing outstanding
//   req_v_o, req_addr_o, req_ready_i : load requests toward the ROM endpoint
//   resp_v_i, resp_data_i : returned load data, cannot be back-pressured
//   data_v_o, data_o, data_ready_i   : buffered words toward the host
module bsg_bladerunner_rom_reader #(
    parameter int                      addr_width_p      = 32,
    parameter int                      data_width_p      = 32,
    parameter int                      rom_els_p         = 256,
    parameter logic [addr_width_p-1:0] base_addr_p       = '0,
    parameter int                      max_out_credits_p = 4,
    parameter int                      fifo_els_p        = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             start_i,
    input  logic [$clog2(rom_els_p+1)-1:0]   num_words_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             error_o,
    output logic                             req_v_o,
    output logic [addr_width_p-1:0]          req_addr_o,
    input  logic                             req_ready_i,
    input  logic                             resp_v_i,
    input  logic [data_width_p-1:0]          resp_data_i,
    output logic                             data_v_o,
    output logic [data_width_p-1:0]          data_o,
    input  logic                             data_ready_i
);
    localparam int cnt_w = $clog2(rom_els_p+1);
    localparam int out_w = $clog2(max_out_credits_p+1);
    localparam int fc_w  = $clog2(fifo_els_p+1);
    localparam int ptr_w = fifo_els_p > 1 ? $clog2(fifo_els_p) : 1;
    localparam int sum_w = $clog2(max_out_credits_p+fifo_els_p+1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                  state_r, state_n;
    logic [cnt_w-1:0]        remaining_r, index_r;
    logic [out_w-1:0]        out_r;
    logic [fc_w-1:0]         count_r;
    logic [ptr_w-1:0]        rd_ptr_r, wr_ptr_r;
    logic [data_width_p-1:0] mem_r [fifo_els_p];
    logic                    error_r;
    logic                    start_acc, credit_ok, req_hs, resp_ok, resp_bad, pop;

    // Reserving FIFO space for every load in flight guarantees each response has a slot.
    assign credit_ok  = (out_r < out_w'(max_out_credits_p))
                     && (sum_w'(out_r) + sum_w'(count_r) < sum_w'(fifo_els_p));
    assign start_acc  = state_r == IDLE && start_i;
    assign req_v_o    = state_r == ISSUE && credit_ok;
    assign req_addr_o = state_r == ISSUE ? base_addr_p + addr_width_p'(index_r) : '0;
    assign req_hs     = req_v_o && req_ready_i;
    assign resp_ok    = resp_v_i && out_r != '0;
    assign resp_bad   = resp_v_i && out_r == '0;
    assign data_v_o   = count_r != '0;
    assign data_o     = mem_r[rd_ptr_r];
    assign pop        = data_v_o && data_ready_i;
    assign busy_o     = state_r != IDLE;
    assign done_o     = state_r == DONE;
    assign error_o    = error_r;

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            IDLE:    state_n = start_i ? (num_words_i != '0 ? ISSUE : DONE) : IDLE;
            ISSUE:   state_n = req_hs && remaining_r == cnt_w'(1) ? DRAIN : ISSUE;
            DRAIN:   state_n = out_r == '0 && count_r == '0 ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            remaining_r <= '0;
            index_r     <= '0;
            out_r       <= '0;
            count_r     <= '0;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            error_r     <= 1'b0;
        end else begin
            state_r <= state_n;
            if (start_acc) begin
                remaining_r <= num_words_i;
                index_r     <= '0;
            end else if (req_hs) begin
                remaining_r <= remaining_r - cnt_w'(1);
                index_r     <= index_r + cnt_w'(1);
            end
            out_r   <= out_r + out_w'(req_hs) - out_w'(resp_ok);
            count_r <= count_r + fc_w'(resp_ok) - fc_w'(pop);
            if (resp_ok)
                wr_ptr_r <= wr_ptr_r == ptr_w'(fifo_els_p-1) ? '0 : wr_ptr_r + ptr_w'(1);
            if (pop)
                rd_ptr_r <= rd_ptr_r == ptr_w'(fifo_els_p-1) ? '0 : rd_ptr_r + ptr_w'(1);
            // A stray response is recorded even if it coincides with a new start.
            if (resp_bad)
                error_r <= 1'b1;
            else if (start_acc)
                error_r <= 1'b0;
        end
    end

    // Storage needs no reset: the head is only meaningful while data_v_o is high.
    always_ff @(posedge clk_i) begin
        if (resp_ok)
            mem_r[wr_ptr_r] <= resp_data_i;
    end
endmodule

// File: tb/tb_bsg_bladerunner_rom_reader.sv
// tb_bsg_bladerunner_rom_reader: scoreboard bench with a latency-configurable ROM model
module tb_bsg_bladerunner_rom_reader;
    logic       clk_i = 0;
    logic       reset_n_i;
    logic       start_i;
    logic [4:0] num_words_i;
    logic       busy_o, done_o, error_o;
    logic       req_v_o;
    logic [7:0] req_addr_o;
    logic       req_ready_i;
    logic       resp_v_i;
    logic [7:0] resp_data_i;
    logic       data_v_o;
    logic [7:0] data_o;
    logic       data_ready_i;

    bsg_bladerunner_rom_reader #(
        .addr_width_p(8), .data_width_p(8), .rom_els_p(16), .base_addr_p(8'h40),
        .max_out_credits_p(2), .fifo_els_p(4)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .num_words_i(num_words_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .req_v_o(req_v_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
        .resp_v_i(resp_v_i), .resp_data_i(resp_data_i),
        .data_v_o(data_v_o), .data_o(data_o), .data_ready_i(data_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0, total = 0;
    int cyc = 0, lat = 1, nreq = 0, nword = 0, run_base = 0, tb_out = 0;
    int spur_req = 0, spur_done = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rom_dat[$];
    int         rom_due[$];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    endtask

    always @(posedge clk_i) cyc++;

    // Monitor and ROM model: evaluated mid-cycle, each action describes the coming edge.
    always @(negedge clk_i) begin
        logic [7:0] ea;
        resp_v_i    = 1'b0;
        resp_data_i = '0;
        if (!reset_n_i) begin
            tb_out = 0;
            exp_q.delete();
        end else begin
            if (req_v_o) chk("credit", 32'(tb_out < 2 && exp_q.size() < 4), 1);
            if (data_v_o && data_ready_i) begin
                if (exp_q.size() == 0) chk("data_unexpected", {24'b0, data_o}, 32'h100);
                else chk("data", {24'b0, data_o}, {24'b0, exp_q.pop_front()});
                nword++;
            end
            if (req_v_o && req_ready_i) begin
                ea = 8'h40 + 8'(nreq - run_base);
                chk("req_addr", {24'b0, req_addr_o}, {24'b0, ea});
                exp_q.push_back(ea ^ 8'hA5);
                rom_due.push_back(cyc + lat);
                rom_dat.push_back(req_addr_o ^ 8'hA5);
                tb_out++;
                nreq++;
            end
        end
        if (spur_req != spur_done) begin
            resp_v_i    = 1'b1;
            resp_data_i = 8'h77;
            spur_done++;
        end else if (rom_due.size() > 0 && rom_due[0] <= cyc) begin
            resp_v_i    = 1'b1;
            resp_data_i = rom_dat.pop_front();
            void'(rom_due.pop_front());
            if (tb_out > 0) tb_out--;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input int n);
        start_i     = 1'b1;
        num_words_i = 5'(n);
        run_base    = nreq;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_o; i++) tick();
        chk("done_seen", 32'(done_o), 1);
        tick();
        chk("done_one_cycle", 32'(done_o), 0);
        chk("idle_after_done", 32'(busy_o), 0);
    endtask

    initial begin
        int r0, w0;
        reset_n_i = 0; start_i = 0; num_words_i = 0; req_ready_i = 1; data_ready_i = 1;
        repeat (2) tick();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_error", 32'(error_o), 0);
        chk("rst_req_v", 32'(req_v_o), 0);
        chk("rst_req_addr", {24'b0, req_addr_o}, 0);
        chk("rst_data_v", 32'(data_v_o), 0);
        reset_n_i = 1;
        tick();

        r0 = nreq; w0 = nword;
        start(3);
        chk("basic_busy", 32'(busy_o), 1);
        chk("basic_first_req_v", 32'(req_v_o), 1);
        chk("basic_first_addr", {24'b0, req_addr_o}, 32'h40);
        wait_done(50);
        chk("basic_reqs", 32'(nreq - r0), 3);
        chk("basic_words", 32'(nword - w0), 3);

        r0 = nreq; w0 = nword;
        data_ready_i = 0;
        start(8);
        repeat (20) tick();
        chk("bp_reqs_stalled", 32'(nreq - r0), 4);
        chk("bp_req_v_low", 32'(req_v_o), 0);
        chk("bp_data_v", 32'(data_v_o), 1);
        data_ready_i = 1;
        wait_done(100);
        chk("bp_reqs", 32'(nreq - r0), 8);
        chk("bp_words", 32'(nword - w0), 8);

        r0 = nreq; w0 = nword;
        lat = 5;
        start(6);
        wait_done(200);
        chk("credit_reqs", 32'(nreq - r0), 6);
        chk("credit_words", 32'(nword - w0), 6);
        lat = 1;

        r0 = nreq;
        start(0);
        chk("zero_done", 32'(done_o), 1);
        chk("zero_req_v", 32'(req_v_o), 0);
        tick();
        chk("zero_done_drop", 32'(done_o), 0);
        chk("zero_idle", 32'(busy_o), 0);
        chk("zero_reqs", 32'(nreq - r0), 0);

        r0 = nreq;
        start(4);
        tick();
        start_i = 1; num_words_i = 10;
        tick();
        start_i = 0;
        wait_done(100);
        chk("ignored_start_reqs", 32'(nreq - r0), 4);

        spur_req++;
        repeat (3) tick();
        chk("spur_error", 32'(error_o), 1);
        chk("spur_data_v", 32'(data_v_o), 0);
        chk("spur_idle", 32'(busy_o), 0);
        start(1);
        chk("spur_error_cleared", 32'(error_o), 0);
        wait_done(50);

        r0 = nreq;
        lat = 5;
        start(6);
        for (int i = 0; i < 50 && nreq - r0 < 2; i++) tick();
        chk("rst_mid_reqs", 32'(nreq - r0), 2);
        #1 reset_n_i = 0;
        #1;
        chk("rst_mid_busy", 32'(busy_o), 0);
        chk("rst_mid_req_v", 32'(req_v_o), 0);
        chk("rst_mid_req_addr", {24'b0, req_addr_o}, 0);
        chk("rst_mid_data_v", 32'(data_v_o), 0);
        chk("rst_mid_error", 32'(error_o), 0);
        tick();
        reset_n_i = 1;
        repeat (12) tick();
        chk("stray_error", 32'(error_o), 1);
        chk("stray_data_v", 32'(data_v_o), 0);
        chk("stray_idle", 32'(busy_o), 0);

        w0 = nword;
        lat = 1;
        start(2);
        chk("recover_error_cleared", 32'(error_o), 0);
        wait_done(50);
        chk("recover_words", 32'(nword - w0), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, %0d/%0d checks passed so far", passed, total);
        $fatal(1);
    end
endmodule
